qaccel_result_drain: RTL and testbench

//  Consumer side of the accelerator result interface. Captures each valid
//  2*DATA_WIDTH-bit result, buffers it in a FIFO, and streams it out as

---
 rtl/qaccel_result_drain.sv | 137 +++++++++++++
 tb/tb_qaccel_result_drain.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/qaccel_result_drain.sv
// qaccel_result_drain: captures 2*DATA_WIDTH-bit accelerator results into a
// FIFO and streams each one out as BEAT_WIDTH-bit beats, LSB beat first.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   valid_in, q_in  result capture strobe and data
//   m_valid, m_ready, m_data, m_last  beat stream (valid/ready)
//   level           FIFO occupancy, not counting the result being serialized
//   overflow        sticky drop flag, cleared by clear_overflow
//   result_count    results fully delivered (wraps)
module qaccel_result_drain #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BEAT_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [2*DATA_WIDTH-1:0]       q_in,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [BEAT_WIDTH-1:0]         m_data,
  output logic                          m_last,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [31:0]                   result_count
);

  localparam int unsigned QW    = 2 * DATA_WIDTH;
  localparam int unsigned BEATS = QW / BEAT_WIDTH;
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = PW + 1;
  localparam int unsigned IW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Parameter sanity checks at elaboration
  if ((QW % BEAT_WIDTH) != 0) begin : g_bad_beat_width
    $error("qaccel_result_drain: result width must be a multiple of BEAT_WIDTH");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("qaccel_result_drain: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q;
  logic [QW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic [QW-1:0]     shift_q;
  logic [IW-1:0]     beat_idx_q;
  logic              m_valid_q, m_last_q;
  logic              overflow_q, overflow_d;
  logic [31:0]       count_q;

  logic full_c, push_c, hs_c, last_hs_c, pop_c;

  // Push/pop decisions use registered level only; no bypass when full
  always_comb begin
    full_c     = (level_q == LW'(FIFO_DEPTH));
    push_c     = valid_in & ~full_c;
    hs_c       = m_valid_q & m_ready;
    last_hs_c  = hs_c & m_last_q;
    pop_c      = (level_q != '0) && ((state_q == IDLE) || last_hs_c);
    level_d    = level_q + LW'(push_c) - LW'(pop_c);
    // Set wins over clear so a drop in the clearing cycle is not lost
    overflow_d = (valid_in & full_c) ? 1'b1 :
                 (clear_overflow ? 1'b0 : overflow_q);
  end

  // Result storage; contents need no reset since pointers gate all reads
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= q_in;
  end

  // Pointers, flags, and serializer FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      shift_q    <= '0;
      beat_idx_q <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      level_q    <= level_d;
      overflow_q <= overflow_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);

      case (state_q)
        IDLE: begin
          if (pop_c) begin
            shift_q    <= mem_q[rd_ptr_q];
            beat_idx_q <= '0;
            m_valid_q  <= 1'b1;
            m_last_q   <= (BEATS == 1);
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (hs_c) begin
            if (!m_last_q) begin
              shift_q    <= shift_q >> BEAT_WIDTH;
              beat_idx_q <= beat_idx_q + IW'(1);
              m_last_q   <= (beat_idx_q == IW'(BEATS - 2));
            end else begin
              count_q <= count_q + 32'd1;
              // Back-to-back reload keeps the beat stream bubble-free
              if (pop_c) begin
                shift_q    <= mem_q[rd_ptr_q];
                beat_idx_q <= '0;
                m_last_q   <= (BEATS == 1);
              end else begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
                state_q   <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_valid      = m_valid_q;
  assign m_data       = shift_q[BEAT_WIDTH-1:0];
  assign m_last       = m_last_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign result_count = count_q;

endmodule

// File: tb/tb_qaccel_result_drain.sv
// Directed bench for qaccel_result_drain (64/32/8 configuration, 4 beats).
module tb_qaccel_result_drain;

  logic         clk;
  logic         rst;
  logic         valid_in;
  logic [127:0] q_in;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic [3:0]   level;
  logic         overflow;
  logic         clear_overflow;
  logic [31:0]  result_count;

  int checks = 0;
  int errors = 0;

  qaccel_result_drain #(
    .DATA_WIDTH(64), .BEAT_WIDTH(32), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .q_in(q_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .level(level), .overflow(overflow), .clear_overflow(clear_overflow),
    .result_count(result_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word j of result k in test t: distinct, position-identifying pattern
  function automatic logic [31:0] wd(input int unsigned t, input int unsigned k,
                                     input int unsigned j);
    return 32'((t << 24) | (k << 8) | j);
  endfunction

  function automatic logic [127:0] res(input int unsigned t, input int unsigned k);
    return {wd(t, k, 3), wd(t, k, 2), wd(t, k, 1), wd(t, k, 0)};
  endfunction

  task automatic chk_beat(input string tag, input logic [31:0] d, input logic l);
    chk({tag, ".valid"}, 64'(m_valid), 64'd1);
    chk({tag, ".data"},  64'(m_data),  64'(d));
    chk({tag, ".last"},  64'(m_last),  64'(l));
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; q_in = '0; m_ready = 1'b1; clear_overflow = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.valid", 64'(m_valid), 64'd0);
    chk("rst.last",  64'(m_last),  64'd0);
    chk("rst.level", 64'(level),   64'd0);
    chk("rst.ovf",   64'(overflow), 64'd0);
    chk("rst.count", 64'(result_count), 64'd0);

    // 1: single result, latency and LSB-first beat order
    valid_in = 1'b1; q_in = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    @(negedge clk); valid_in = 1'b0;
    chk("t1.valid_t1", 64'(m_valid), 64'd0);
    chk("t1.level_t1", 64'(level), 64'd1);
    @(negedge clk); chk_beat("t1.b0", 32'hCCDDEEFF, 1'b0);
    @(negedge clk); chk_beat("t1.b1", 32'h8899AABB, 1'b0);
    @(negedge clk); chk_beat("t1.b2", 32'h44556677, 1'b0);
    @(negedge clk); chk_beat("t1.b3", 32'h00112233, 1'b1);
    @(negedge clk);
    chk("t1.idle", 64'(m_valid), 64'd0);
    chk("t1.count", 64'(result_count), 64'd1);

    // 2: three back-to-back results, 12 contiguous beats
    valid_in = 1'b1; q_in = res(2, 0);
    @(negedge clk); q_in = res(2, 1);
    @(negedge clk); q_in = res(2, 2);
    for (int i = 0; i < 12; i++) begin
      chk_beat($sformatf("t2.b%0d", i), wd(2, i / 4, i % 4), (i % 4) == 3);
      @(negedge clk);
      if (i == 0) valid_in = 1'b0;
    end
    chk("t2.idle", 64'(m_valid), 64'd0);
    chk("t2.level", 64'(level), 64'd0);
    chk("t2.count", 64'(result_count), 64'd4);

    // 3: stalled sink, 10 pushes -> 1 serializing + 8 queued + 1 dropped
    m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      valid_in = 1'b1; q_in = res(3, k);
      @(negedge clk);
    end
    valid_in = 1'b0;
    chk("t3.level", 64'(level), 64'd8);
    chk("t3.ovf", 64'(overflow), 64'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 36; i++) begin
      chk_beat($sformatf("t3.b%0d", i), wd(3, i / 4, i % 4), (i % 4) == 3);
      @(negedge clk);
    end
    chk("t3.idle", 64'(m_valid), 64'd0);
    chk("t3.level0", 64'(level), 64'd0);
    chk("t3.count", 64'(result_count), 64'd13);

    // 4: ready toggling 1,0,0,1 mid-result and a stall on the last beat
    valid_in = 1'b1; q_in = res(4, 0);
    @(negedge clk); valid_in = 1'b0;
    @(negedge clk); chk_beat("t4.b0", wd(4, 0, 0), 1'b0);
    @(negedge clk); chk_beat("t4.b1", wd(4, 0, 1), 1'b0); m_ready = 1'b0;
    @(negedge clk); chk_beat("t4.b1hold", wd(4, 0, 1), 1'b0);
    @(negedge clk); chk_beat("t4.b1hold2", wd(4, 0, 1), 1'b0); m_ready = 1'b1;
    @(negedge clk); chk_beat("t4.b2", wd(4, 0, 2), 1'b0);
    @(negedge clk); chk_beat("t4.b3", wd(4, 0, 3), 1'b1); m_ready = 1'b0;
    @(negedge clk); chk_beat("t4.b3hold", wd(4, 0, 3), 1'b1); m_ready = 1'b1;
    @(negedge clk);
    chk("t4.idle", 64'(m_valid), 64'd0);
    chk("t4.count", 64'(result_count), 64'd14);

    // 5: reset after the second beat with three results queued
    valid_in = 1'b1; q_in = res(5, 0);
    @(negedge clk); q_in = res(5, 1);
    @(negedge clk); q_in = res(5, 2); chk_beat("t5.b0", wd(5, 0, 0), 1'b0);
    @(negedge clk); q_in = res(5, 3); chk_beat("t5.b1", wd(5, 0, 1), 1'b0);
    @(negedge clk); valid_in = 1'b0;
    chk("t5.level_pre", 64'(level), 64'd3);
    chk_beat("t5.b2", wd(5, 0, 2), 1'b0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t5.valid", 64'(m_valid), 64'd0);
    chk("t5.last", 64'(m_last), 64'd0);
    chk("t5.data", 64'(m_data), 64'd0);
    chk("t5.level", 64'(level), 64'd0);
    chk("t5.count", 64'(result_count), 64'd0);
    chk("t5.ovf", 64'(overflow), 64'd0);
    valid_in = 1'b1; q_in = res(5, 9);
    @(negedge clk); valid_in = 1'b0;
    chk("t5.after_idle", 64'(m_valid), 64'd0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); chk_beat($sformatf("t5.n%0d", j), wd(5, 9, j), j == 3);
    end
    @(negedge clk);
    chk("t5.end_idle", 64'(m_valid), 64'd0);
    chk("t5.end_count", 64'(result_count), 64'd1);

    // 6: set beats clear in the same cycle; clear alone then works
    m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      valid_in = 1'b1; q_in = res(6, k);
      @(negedge clk);
    end
    chk("t6.ovf_set", 64'(overflow), 64'd1);
    chk("t6.level", 64'(level), 64'd8);
    q_in = res(6, 10); clear_overflow = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    chk("t6.ovf_setwins", 64'(overflow), 64'd1);
    @(negedge clk); clear_overflow = 1'b0;
    chk("t6.ovf_cleared", 64'(overflow), 64'd0);
    chk_beat("t6.b0", wd(6, 0, 0), 1'b0);
    m_ready = 1'b1;
    repeat (36) @(negedge clk);
    chk("t6.idle", 64'(m_valid), 64'd0);
    chk("t6.level0", 64'(level), 64'd0);
    chk("t6.count", 64'(result_count), 64'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
